audio_codec_responder: RTL and testbench

- Codec-side responder for the audio serial port that the audio core drives as master (BCLK, LRCK, DAC data out; ADC data in).
- Oversamples BCLK, LRCK and DACDAT on the system clock.
- Deserializes each stereo DAC frame into parallel 16-bit samples, and serializes host-supplied ADC samples back onto ADCDAT.
- Used as a synthesizable loopback/codec stand-in for bring-up and as the DUT-facing end in audio-path benches.

---
 rtl/audio_codec_responder.sv | 120 ++++++++++++
 tb/tb_audio_codec_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_responder.sv
// audio_codec_responder: codec-side end of a left-justified stereo serial link.
// Oversamples the master's BCLK/LRCK/DACDAT, deserializes DAC frames and serializes host ADC samples.
module audio_codec_responder #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              Reset,
    input  logic              iAUD_BCLK,
    input  logic              iAUD_LRCK,
    input  logic              iAUD_DACDAT,
    output logic              oAUD_ADCDAT,
    input  logic [DATA_W-1:0] iADC_L,
    input  logic [DATA_W-1:0] iADC_R,
    output logic              oADC_LOAD,
    output logic [DATA_W-1:0] oDAC_L,
    output logic [DATA_W-1:0] oDAC_R,
    output logic              oDAC_VALID,
    output logic              oFRAME_ERR
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} stateT;

    stateT                  state, stateNext;
    logic [SYNC_STAGES-1:0] bclkSync, lrSync, datSync;
    logic                   bclkHist, lrHist, datHist;
    logic [SYNC_STAGES:0]   primed;
    logic                   bclkRise, bclkFall, lrRise, lrFall, lrEdge;
    logic                   closeLeft, closeRight, shortCh, seenRise;
    logic [CW-1:0]          bitCnt;
    logic [DATA_W-1:0]      rxShift, rxAligned, pendL, holdR, txShift;

    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) begin
            bclkSync <= '0;
            lrSync   <= '0;
            datSync  <= '0;
            bclkHist <= 1'b0;
            lrHist   <= 1'b0;
            datHist  <= 1'b0;
            primed   <= '0;
        end else begin
            bclkSync <= {bclkSync[SYNC_STAGES-2:0], iAUD_BCLK};
            lrSync   <= {lrSync[SYNC_STAGES-2:0], iAUD_LRCK};
            datSync  <= {datSync[SYNC_STAGES-2:0], iAUD_DACDAT};
            bclkHist <= bclkSync[SYNC_STAGES-1];
            lrHist   <= lrSync[SYNC_STAGES-1];
            datHist  <= datSync[SYNC_STAGES-1];
            primed   <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges stay masked until the history flops hold real pin levels, so a pin that is
    // already high when reset releases is not mistaken for a fresh edge.
    always_comb begin
        bclkRise   = primed[SYNC_STAGES] & bclkSync[SYNC_STAGES-1] & ~bclkHist;
        bclkFall   = primed[SYNC_STAGES] & ~bclkSync[SYNC_STAGES-1] & bclkHist;
        lrRise     = primed[SYNC_STAGES] & lrSync[SYNC_STAGES-1] & ~lrHist;
        lrFall     = primed[SYNC_STAGES] & ~lrSync[SYNC_STAGES-1] & lrHist;
        lrEdge     = lrRise | lrFall;
        closeLeft  = lrFall && state == LEFT;
        closeRight = lrRise && state == RIGHT;
        shortCh    = bitCnt < CW'(DATA_W);
        rxAligned  = rxShift << (CW'(DATA_W) - bitCnt);
        stateNext  = lrRise ? LEFT : closeLeft ? RIGHT : state;
    end

    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) begin
            oADC_LOAD   <= 1'b0;
            oDAC_VALID  <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oAUD_ADCDAT <= 1'b0;
            oDAC_L      <= '0;
            oDAC_R      <= '0;
            pendL       <= '0;
            holdR       <= '0;
            txShift     <= '0;
            rxShift     <= '0;
            bitCnt      <= '0;
            seenRise    <= 1'b0;
        end else begin
            oADC_LOAD   <= lrRise;
            oDAC_VALID  <= closeRight;
            oFRAME_ERR  <= (closeLeft | closeRight) & shortCh;
            oAUD_ADCDAT <= state != IDLE && txShift[DATA_W-1];
            if (closeLeft) pendL <= rxAligned;
            if (closeRight) begin
                oDAC_L <= pendL;
                oDAC_R <= rxAligned;
            end
            if (lrRise) begin
                holdR   <= iADC_R;
                txShift <= iADC_L;
            end else if (lrFall) begin
                txShift <= holdR;
            end else if (bclkFall && seenRise) begin
                txShift <= txShift << 1;
            end
            // LRCK edge wins: a coincident BCLK rise becomes bit 0 of the new channel.
            if (lrEdge) begin
                bitCnt   <= CW'(bclkRise);
                rxShift  <= bclkRise ? DATA_W'(datHist) : '0;
                seenRise <= bclkRise;
            end else if (bclkRise) begin
                seenRise <= 1'b1;
                if (shortCh) begin
                    bitCnt  <= bitCnt + 1'b1;
                    rxShift <= {rxShift[DATA_W-2:0], datHist};
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_codec_responder.sv
// tb_audio_codec_responder: drives a left-justified master and checks DAC/ADC paths
// against a word-level model of the link.
module tb_audio_codec_responder;
    localparam int HALF = 8;

    logic        iCLK = 1'b0;
    logic        Reset = 1'b1;
    logic        iAUD_BCLK = 1'b0;
    logic        iAUD_LRCK = 1'b0;
    logic        iAUD_DACDAT = 1'b0;
    logic        oAUD_ADCDAT;
    logic [15:0] iADC_L = '0;
    logic [15:0] iADC_R = '0;
    logic        oADC_LOAD;
    logic [15:0] oDAC_L, oDAC_R;
    logic        oDAC_VALID, oFRAME_ERR;

    int          passCnt = 0, totalCnt = 0;
    int          validCnt = 0, errCnt = 0, loadCnt = 0;
    logic [15:0] lastL = '0, lastR = '0;
    logic [15:0] nextAdcL, nextAdcR, txL, txR;

    audio_codec_responder #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .iCLK(iCLK), .Reset(Reset), .iAUD_BCLK(iAUD_BCLK), .iAUD_LRCK(iAUD_LRCK),
        .iAUD_DACDAT(iAUD_DACDAT), .oAUD_ADCDAT(oAUD_ADCDAT), .iADC_L(iADC_L), .iADC_R(iADC_R),
        .oADC_LOAD(oADC_LOAD), .oDAC_L(oDAC_L), .oDAC_R(oDAC_R), .oDAC_VALID(oDAC_VALID),
        .oFRAME_ERR(oFRAME_ERR)
    );

    always #10 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (!Reset) begin
            if (oDAC_VALID) begin
                validCnt++;
                lastL = oDAC_L;
                lastR = oDAC_R;
            end
            if (oFRAME_ERR) errCnt++;
            if (oADC_LOAD) loadCnt++;
        end
    end

    // Expected DAC word: first min(n,16) bits sent, left-aligned with zero LSBs.
    function automatic logic [15:0] rx_expect(input int n, input logic [31:0] pat);
        logic [15:0] w;
        w = pat[31:16];
        return n >= 16 ? w : w & (16'hFFFF << (16 - n));
    endfunction

    // Expected master capture over n BCLKs: the 16-bit word then zeros.
    function automatic logic [31:0] tx_expect(input int n, input logic [15:0] w);
        logic [31:0] full;
        full = {w, 16'h0};
        return full & ~(32'hFFFF_FFFF >> n);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic send_ch(input logic lr, input int n, input logic [31:0] pat, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) iAUD_LRCK = lr;
            iAUD_DACDAT = pat[31-i];
            wait_clk(HALF);
            cap[31-i] = oAUD_ADCDAT;
            iAUD_BCLK = 1'b1;
            wait_clk(HALF);
            iAUD_BCLK = 1'b0;
        end
    endtask

    task automatic rise_edge();
        iADC_L = nextAdcL;
        iADC_R = nextAdcR;
        txL = nextAdcL;
        txR = nextAdcR;
        nextAdcL = 16'($urandom);
        nextAdcR = 16'($urandom);
        iAUD_LRCK = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_frame(input int nL, input logic [31:0] pL, input int nR, input logic [31:0] pR,
                              output logic [31:0] cL, output logic [31:0] cR,
                              output logic [15:0] sL, output logic [15:0] sR);
        if (!iAUD_LRCK) rise_edge();
        sL = txL;
        sR = txR;
        send_ch(1'b1, nL, pL, cL);
        send_ch(1'b0, nR, pR, cR);
        rise_edge();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        iAUD_LRCK = 1'b0;
        iAUD_BCLK = 1'b0;
        wait_clk(4);
        Reset = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_reset();
        wait_clk(3);
        totalCnt++; if ({oDAC_L, oDAC_R} !== 32'h0) $display("FAIL reset_dac: got %h want 0", {oDAC_L, oDAC_R}); else passCnt++;
        totalCnt++; if ({oDAC_VALID, oFRAME_ERR, oADC_LOAD, oAUD_ADCDAT} !== 4'h0) $display("FAIL reset_flags: got %b want 0000", {oDAC_VALID, oFRAME_ERR, oADC_LOAD, oAUD_ADCDAT}); else passCnt++;
        Reset = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_nominal();
        logic [31:0] cL, cR;
        logic [15:0] sL, sR;
        int v0, e0;
        v0 = validCnt; e0 = errCnt;
        send_frame(16, 32'hA5C3_0000, 16, 32'h1234_0000, cL, cR, sL, sR);
        totalCnt++; if (validCnt - v0 !== 1) $display("FAIL nominal_valid: got %0d want 1", validCnt - v0); else passCnt++;
        totalCnt++; if (lastL !== 16'hA5C3) $display("FAIL nominal_L: got %h want a5c3", lastL); else passCnt++;
        totalCnt++; if (lastR !== 16'h1234) $display("FAIL nominal_R: got %h want 1234", lastR); else passCnt++;
        totalCnt++; if (errCnt - e0 !== 0) $display("FAIL nominal_err: got %0d want 0", errCnt - e0); else passCnt++;
        totalCnt++; if (cL !== tx_expect(16, sL)) $display("FAIL nominal_adcL: got %h want %h", cL, tx_expect(16, sL)); else passCnt++;
        totalCnt++; if (cR !== tx_expect(16, sR)) $display("FAIL nominal_adcR: got %h want %h", cR, tx_expect(16, sR)); else passCnt++;
        wait_clk(20);
        totalCnt++; if ({oDAC_L, oDAC_R} !== 32'hA5C3_1234) $display("FAIL nominal_hold: got %h want a5c31234", {oDAC_L, oDAC_R}); else passCnt++;
    endtask

    task automatic test_adc_serial();
        logic [31:0] cL, cR, pL, pR;
        logic [15:0] sL, sR;
        int l0;
        nextAdcL = 16'h8001;
        nextAdcR = 16'h7FFE;
        do_reset();
        l0 = loadCnt;
        pL = $urandom; pR = $urandom;
        send_frame(32, pL, 32, pR, cL, cR, sL, sR);
        totalCnt++; if (cL !== 32'h8001_0000) $display("FAIL adc_L: got %h want 80010000", cL); else passCnt++;
        totalCnt++; if (cR !== 32'h7FFE_0000) $display("FAIL adc_R: got %h want 7ffe0000", cR); else passCnt++;
        totalCnt++; if (loadCnt - l0 !== 2) $display("FAIL adc_load: got %0d want 2", loadCnt - l0); else passCnt++;
        totalCnt++; if ({lastL, lastR} !== {rx_expect(32, pL), rx_expect(32, pR)}) $display("FAIL adc_dac: got %h want %h", {lastL, lastR}, {rx_expect(32, pL), rx_expect(32, pR)}); else passCnt++;
    endtask

    task automatic test_short_channel();
        logic [31:0] cL, cR, pL;
        logic [15:0] sL, sR;
        int v0, e0;
        v0 = validCnt; e0 = errCnt;
        pL = $urandom;
        send_frame(16, pL, 12, 32'hFFF0_0000, cL, cR, sL, sR);
        totalCnt++; if (validCnt - v0 !== 1) $display("FAIL short_valid: got %0d want 1", validCnt - v0); else passCnt++;
        totalCnt++; if (lastR !== 16'hFFF0) $display("FAIL short_R: got %h want fff0", lastR); else passCnt++;
        totalCnt++; if (lastL !== rx_expect(16, pL)) $display("FAIL short_L: got %h want %h", lastL, rx_expect(16, pL)); else passCnt++;
        totalCnt++; if (errCnt - e0 !== 1) $display("FAIL short_err: got %0d want 1", errCnt - e0); else passCnt++;
        totalCnt++; if (cR !== tx_expect(12, sR)) $display("FAIL short_adcR: got %h want %h", cR, tx_expect(12, sR)); else passCnt++;
    endtask

    task automatic test_long_channel();
        logic [31:0] cL, cR, pL, pR;
        logic [15:0] sL, sR;
        int v0, e0;
        v0 = validCnt; e0 = errCnt;
        pL = {16'hBEEF, 16'($urandom)};
        pR = $urandom;
        send_frame(24, pL, 24, pR, cL, cR, sL, sR);
        totalCnt++; if (lastL !== 16'hBEEF) $display("FAIL long_L: got %h want beef", lastL); else passCnt++;
        totalCnt++; if (lastR !== rx_expect(24, pR)) $display("FAIL long_R: got %h want %h", lastR, rx_expect(24, pR)); else passCnt++;
        totalCnt++; if (errCnt - e0 !== 0 || validCnt - v0 !== 1) $display("FAIL long_err_valid: got %0d/%0d want 0/1", errCnt - e0, validCnt - v0); else passCnt++;
        totalCnt++; if (cL !== tx_expect(24, sL)) $display("FAIL long_adcL: got %h want %h", cL, tx_expect(24, sL)); else passCnt++;
    endtask

    task automatic test_random_frames();
        logic [31:0] cL, cR, pL, pR;
        logic [15:0] sL, sR;
        int v0, e0, nL, nR, expErr;
        for (int k = 0; k < 6; k++) begin
            v0 = validCnt; e0 = errCnt;
            nL = $urandom_range(6, 28);
            nR = $urandom_range(6, 28);
            pL = $urandom; pR = $urandom;
            expErr = (nL < 16 ? 1 : 0) + (nR < 16 ? 1 : 0);
            send_frame(nL, pL, nR, pR, cL, cR, sL, sR);
            totalCnt++; if (validCnt - v0 !== 1) $display("FAIL rand%0d_valid: got %0d want 1", k, validCnt - v0); else passCnt++;
            totalCnt++; if (lastL !== rx_expect(nL, pL)) $display("FAIL rand%0d_L: got %h want %h", k, lastL, rx_expect(nL, pL)); else passCnt++;
            totalCnt++; if (lastR !== rx_expect(nR, pR)) $display("FAIL rand%0d_R: got %h want %h", k, lastR, rx_expect(nR, pR)); else passCnt++;
            totalCnt++; if (errCnt - e0 !== expErr) $display("FAIL rand%0d_err: got %0d want %0d", k, errCnt - e0, expErr); else passCnt++;
            totalCnt++; if (cL !== tx_expect(nL, sL)) $display("FAIL rand%0d_adcL: got %h want %h", k, cL, tx_expect(nL, sL)); else passCnt++;
            totalCnt++; if (cR !== tx_expect(nR, sR)) $display("FAIL rand%0d_adcR: got %h want %h", k, cR, tx_expect(nR, sR)); else passCnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] cL, cR, pL, pR, junk;
        logic [15:0] sL, sR;
        int v0, e0;
        send_ch(1'b1, 7, $urandom, junk);
        Reset = 1'b1;
        #1;
        totalCnt++; if ({oDAC_L, oDAC_R} !== 32'h0) $display("FAIL midrst_dac: got %h want 0", {oDAC_L, oDAC_R}); else passCnt++;
        totalCnt++; if ({oDAC_VALID, oFRAME_ERR, oADC_LOAD, oAUD_ADCDAT} !== 4'h0) $display("FAIL midrst_flags: got %b want 0000", {oDAC_VALID, oFRAME_ERR, oADC_LOAD, oAUD_ADCDAT}); else passCnt++;
        wait_clk(4);
        Reset = 1'b0;
        wait_clk(6);
        v0 = validCnt; e0 = errCnt;
        send_ch(1'b1, 9, $urandom, junk);
        send_ch(1'b0, 16, $urandom, cR);
        rise_edge();
        totalCnt++; if (cR !== 32'h0) $display("FAIL midrst_idle_adc: got %h want 0", cR); else passCnt++;
        totalCnt++; if (validCnt - v0 !== 0 || errCnt - e0 !== 0) $display("FAIL midrst_quiet: got %0d/%0d want 0/0", validCnt - v0, errCnt - e0); else passCnt++;
        pL = $urandom; pR = $urandom;
        send_frame(16, pL, 16, pR, cL, cR, sL, sR);
        totalCnt++; if (validCnt - v0 !== 1) $display("FAIL midrst_valid: got %0d want 1", validCnt - v0); else passCnt++;
        totalCnt++; if ({lastL, lastR} !== {pL[31:16], pR[31:16]}) $display("FAIL midrst_data: got %h want %h", {lastL, lastR}, {pL[31:16], pR[31:16]}); else passCnt++;
    endtask

    task automatic test_startup_align();
        logic [31:0] cL, cR, pL, pR, junk;
        logic [15:0] sL, sR;
        int v0, e0;
        Reset = 1'b1;
        send_ch(1'b0, 6, $urandom, junk);
        Reset = 1'b0;
        v0 = validCnt; e0 = errCnt;
        send_ch(1'b0, 10, $urandom, cR);
        totalCnt++; if (cR !== 32'h0) $display("FAIL startup_adc: got %h want 0", cR); else passCnt++;
        totalCnt++; if (validCnt - v0 !== 0 || {oDAC_L, oDAC_R} !== 32'h0) $display("FAIL startup_quiet: got %0d %h want 0 0", validCnt - v0, {oDAC_L, oDAC_R}); else passCnt++;
        pL = $urandom; pR = $urandom;
        send_frame(16, pL, 16, pR, cL, cR, sL, sR);
        totalCnt++; if (validCnt - v0 !== 1) $display("FAIL startup_valid: got %0d want 1", validCnt - v0); else passCnt++;
        totalCnt++; if ({lastL, lastR} !== {pL[31:16], pR[31:16]}) $display("FAIL startup_data: got %h want %h", {lastL, lastR}, {pL[31:16], pR[31:16]}); else passCnt++;
        totalCnt++; if (errCnt - e0 !== 0) $display("FAIL startup_err: got %0d want 0", errCnt - e0); else passCnt++;
        totalCnt++; if (cL !== tx_expect(16, sL)) $display("FAIL startup_adcL: got %h want %h", cL, tx_expect(16, sL)); else passCnt++;
    endtask

    initial begin
        nextAdcL = 16'($urandom);
        nextAdcR = 16'($urandom);
        test_reset();
        test_nominal();
        test_adc_serial();
        test_short_channel();
        test_long_channel();
        test_random_frames();
        test_reset_mid_frame();
        test_startup_align();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
